// File: rtl/datapath_pkg.sv
// ============================================================================
// Package : datapath_pkg
// Brief   : Shared constants for the combinational datapath library cells.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package datapath_pkg;

  // Value a registered datapath output takes while its reset is asserted.
  localparam logic DP_RST_VAL = 1'b0;

endpackage : datapath_pkg

`default_nettype wire

// File: rtl/parity_reg.sv
// ============================================================================
// Module  : parity_reg
// Brief   : 1-bit D flop with asynchronous active-high reset to RST_VAL.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_reg
  import datapath_pkg::*;
#(
  parameter logic RST_VAL = DP_RST_VAL
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  // Capture d on each rising edge; reset overrides immediately, no edge needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else begin
      q <= d;
    end
  end

endmodule : parity_reg

`default_nettype wire

// File: rtl/xor4_behavior.sv
// ============================================================================
// Module  : xor4_behavior
// Brief   : 4-input odd-parity cell, optionally registered once.
//           o_f = i_a ^ i_b ^ i_c ^ i_d. X/Z on any input propagates to o_f.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module xor4_behavior
  import datapath_pkg::*;
#(
  parameter bit   REG_OUT = 1'b1,
  parameter logic RST_VAL = DP_RST_VAL
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  input  logic i_d,
  output logic o_f
);

  logic parity;

  // Odd parity of the four inputs; a reduction XOR keeps X propagation intact.
  assign parity = i_a ^ i_b ^ i_c ^ i_d;

  generate
    if (REG_OUT) begin : g_reg
      parity_reg #(
        .RST_VAL (RST_VAL)
      ) u_parity_reg (
        .clk (i_clk),
        .rst (i_rst),
        .d   (parity),
        .q   (o_f)
      );
    end else begin : g_comb
      // Clock and reset have no function in the combinational variant.
      logic unused_clk_rst;
      assign unused_clk_rst = i_clk ^ i_rst;
      assign o_f            = parity;
    end
  endgenerate

endmodule : xor4_behavior

`default_nettype wire

// File: tb/tb_xor4_behavior.sv
// ============================================================================
// Module  : tb_xor4_behavior
// Brief   : Directed self-checking bench for xor4_behavior, registered and
//           combinational variants.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xor4_behavior;

  // Registered instance
  logic clk;
  logic rst;
  logic a, b, c, d;
  logic f;

  // Combinational instance; its clock is never toggled
  logic clk0;
  logic rst0;
  logic ca, cb, cc, cd;
  logic cf;

  int n_cmp;
  int n_bad;

  xor4_behavior #(.REG_OUT(1'b1)) dut_reg (
    .i_clk (clk),
    .i_rst (rst),
    .i_a   (a),
    .i_b   (b),
    .i_c   (c),
    .i_d   (d),
    .o_f   (f)
  );

  xor4_behavior #(.REG_OUT(1'b0)) dut_comb (
    .i_clk (clk0),
    .i_rst (rst0),
    .i_a   (ca),
    .i_b   (cb),
    .i_c   (cc),
    .i_d   (cd),
    .o_f   (cf)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Odd-popcount reference, counted bit by bit
  function automatic logic odd_ones(input logic [3:0] code);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (code[i]) cnt++;
    end
    return (cnt % 2) == 1;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Code bit 3 drives i_a, bit 0 drives i_d
  task automatic drive(input logic [3:0] code);
    a = code[3];
    b = code[2];
    c = code[1];
    d = code[0];
  endtask

  initial begin
    logic [3:0] code;
    logic       prev;
    logic       xprobe;

    n_cmp = 0;
    n_bad = 0;
    clk0  = 1'b0;
    rst0  = 1'b0;
    ca = 1'b0; cb = 1'b0; cc = 1'b0; cd = 1'b0;

    // ---- Reset: forced immediately and held across edges ----
    drive(4'b0001);
    rst = 1'b1;
    #1;
    check("reset_immediate", f, 1'b0);
    @(posedge clk); #1;
    check("reset_hold_edge1", f, 1'b0);
    @(posedge clk); #1;
    check("reset_hold_edge2", f, 1'b0);

    // ---- Reset release with inputs 1110 ----
    @(negedge clk);
    drive(4'b1110);
    rst = 1'b0;
    #1;
    check("release_before_edge", f, 1'b0);
    @(posedge clk); #1;
    check("release_after_edge", f, 1'b1);

    // ---- Exhaustive sweep plus wrap through 0000, 0001 ----
    prev = 1'b1;
    for (int i = 0; i < 18; i++) begin
      code = 4'(i % 16);
      @(negedge clk);
      drive(code);
      #1;
      check($sformatf("sweep_hold_%0d", i), f, prev);
      @(posedge clk); #1;
      check($sformatf("sweep_code_%b", code), f, odd_ones(code));
      prev = odd_ones(code);
    end

    // ---- Truth-table anchors ----
    @(negedge clk); drive(4'b0111);
    @(posedge clk); #1;
    check("tt_0111", f, 1'b1);
    @(negedge clk); drive(4'b1111);
    @(posedge clk); #1;
    check("tt_1111", f, 1'b0);
    @(negedge clk); drive(4'b0011);
    @(posedge clk); #1;
    check("tt_0011", f, 1'b0);

    // ---- Async reset mid-operation with inputs 0001 ----
    @(negedge clk); drive(4'b0001);
    @(posedge clk); #1;
    check("arst_pre_one", f, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_drop_between_edges", f, 1'b0);
    @(posedge clk); #1;
    check("arst_hold_during_reset", f, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_released_no_edge", f, 1'b0);
    @(posedge clk); #1;
    check("arst_resample", f, 1'b1);

    // ---- Latency: mid-cycle toggle of i_a from 0000 ----
    @(negedge clk); drive(4'b0000);
    @(posedge clk); #1;
    check("lat_base", f, 1'b0);
    #2;
    a = 1'b1;
    #1;
    check("lat_mid_cycle", f, 1'b0);
    @(negedge clk); #1;
    check("lat_before_edge", f, 1'b0);
    @(posedge clk); #1;
    check("lat_after_edge", f, 1'b1);

    // ---- Combinational variant, clock stopped ----
    ca = 1'b1; cb = 1'b0; cc = 1'b1; cd = 1'b1;
    #1;
    check("comb_1011", cf, 1'b1);
    cb = 1'b1;
    #1;
    check("comb_1111", cf, 1'b0);
    rst0 = 1'b1;
    cd = 1'b0;
    #1;
    check("comb_ignores_rst", cf, 1'b1);
    rst0 = 1'b0;

    // ---- X propagation (only meaningful on a 4-state simulator) ----
    xprobe = 1'bx;
    @(negedge clk);
    a = 1'bx; b = 1'b0; c = 1'b0; d = 1'b0;
    ca = 1'bx; cb = 1'b0; cc = 1'b0; cd = 1'b0;
    @(posedge clk); #1;
    if (xprobe === 1'bx) begin
      check("xprop_reg", f, 1'bx);
      check("xprop_comb", cf, 1'bx);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_xor4_behavior

`default_nettype wire
